// File: rtl/timer_pkg.sv
// Shared timer types and widths, imported by the timebase and the compare stage.
package timer_pkg;

    localparam int TMR_CNT_W   = 8;
    localparam int TMR_PRESC_W = 3;

    typedef enum logic [1:0] {
        TMR_FREE    = 2'b00,
        TMR_PERIOD  = 2'b01,
        TMR_ONESHOT = 2'b10,
        TMR_RSVD    = 2'b11
    } tmr_mode_e;

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two clock prescaler: emits a tick every 2**presc_sel enabled cycles.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESC_W = TMR_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc_sel,
    output logic               tick
);

    localparam int DIV_W = (1 << PRESC_W) - 1;

    logic [DIV_W-1:0] presc_cnt;
    logic [DIV_W-1:0] terminal;

    // For the largest select the shifted one falls off the top, so the subtraction wraps to all-ones.
    always_comb begin
        terminal = (DIV_W'(1) << presc_sel) - DIV_W'(1);
        tick     = enable && (presc_cnt == terminal);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt <= '0;
        end else if (clear) begin
            presc_cnt <= '0;
        end else if (enable) begin
            presc_cnt <= tick ? '0 : presc_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Timebase counter with FREE/PERIOD/ONESHOT modes feeding the compare/PWM stage.
// Optional prescaler is built only when TIMER_PRESCALER_EN is defined.
module timer_counter
    import timer_pkg::*;
#(
    parameter int CNT_W   = TMR_CNT_W,
    parameter int PRESC_W = TMR_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [PRESC_W-1:0] presc_sel,
    input  logic               sw_clear,
    output logic [CNT_W-1:0]   counter_value,
    output logic               tick,
    output logic               ovf,
    output logic               running,
    output logic               done
);

    tmr_mode_e        mode_e;
    logic             active;
    logic             at_max;
    logic             at_period;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done_nxt;
    logic             ovf_nxt;
    logic             running_nxt;

    assign mode_e = tmr_mode_e'(mode);
    assign active = enable && !done;

`ifdef TIMER_PRESCALER_EN
    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .enable    (active),
        .clear     (sw_clear || !enable),
        .presc_sel (presc_sel),
        .tick      (tick)
    );
`else
    logic unused_presc_sel;
    assign unused_presc_sel = ^presc_sel;
    assign tick             = active;
`endif

    always_comb begin
        at_max    = (counter_value == {CNT_W{1'b1}});
        at_period = (counter_value == period);
        cnt_nxt   = counter_value;
        done_nxt  = done;
        ovf_nxt   = 1'b0;
        if (sw_clear) begin
            cnt_nxt  = '0;
            done_nxt = 1'b0;
        end else if (!enable) begin
            // Dropping enable is the re-arm path for a one-shot.
            if (mode_e == TMR_ONESHOT) begin
                cnt_nxt  = '0;
                done_nxt = 1'b0;
            end
        end else if (tick) begin
            unique case (mode_e)
                TMR_PERIOD: begin
                    if (at_period) begin
                        cnt_nxt = '0;
                        ovf_nxt = 1'b1;
                    end else begin
                        cnt_nxt = counter_value + CNT_W'(1);
                        ovf_nxt = at_max;
                    end
                end
                TMR_ONESHOT: begin
                    if (at_period) begin
                        done_nxt = 1'b1;
                        ovf_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = counter_value + CNT_W'(1);
                        ovf_nxt = at_max;
                    end
                end
                default: begin
                    cnt_nxt = counter_value + CNT_W'(1);
                    ovf_nxt = at_max;
                end
            endcase
        end
        // Uses the next done so running falls on the same edge that finishes a one-shot.
        running_nxt = enable && !done_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_value <= '0;
            done          <= 1'b0;
            ovf           <= 1'b0;
            running       <= 1'b0;
        end else begin
            counter_value <= cnt_nxt;
            done          <= done_nxt;
            ovf           <= ovf_nxt;
            running       <= running_nxt;
        end
    end

endmodule
